// File: rtl/iq_pkg.sv
// iq_pkg: shared sizes and types for the issue-queue scheduler.
package iq_pkg;
    localparam int DEPTH    = 8;
    localparam int IDX_W    = 3;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    typedef logic [IDX_W-1:0] iq_idx_t;
    typedef logic [REG_W-1:0] iq_reg_t;
endpackage

// File: rtl/iq_age_select.sv
// iq_age_select: picks one ready slot; oldest-first age matrix when IQ_OLDEST_FIRST_EN
// is defined, otherwise fixed lowest-index priority.
module iq_age_select
    import iq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc,
    input  iq_idx_t          alloc_idx,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] grant_oh,
    output iq_idx_t          grant_idx,
    output logic             grant_v
);
`ifdef IQ_OLDEST_FIRST_EN
    // older_q[j][i] set means slot j was allocated before slot i
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    always_comb begin
        older_d = older_q;
        if (flush) begin
            older_d = '{default: '0};
        end else if (alloc) begin
            older_d[alloc_idx] = '0;
            for (int j = 0; j < DEPTH; j++) older_d[j][alloc_idx] = valid[j];
        end
    end
    always_comb begin
        logic blk;
        grant_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) blk = blk | (ready[j] & older_q[j][i]);
            grant_oh[i] = ready[i] & ~blk;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) older_q <= '{default: '0};
        else      older_q <= older_d;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, flush, alloc, alloc_idx, valid};
    assign grant_oh  = ready & (~ready + DEPTH'(1));
`endif
    always_comb begin
        grant_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) if (grant_oh[i]) grant_idx = iq_idx_t'(i);
    end
    assign grant_v = |grant_oh;
endmodule

// File: rtl/iq_scheduler.sv
// iq_scheduler: issue-queue control - scoreboard, slot allocation, wakeup and select.
// Define IQ_OLDEST_FIRST_EN for oldest-first select instead of lowest-index.
module iq_scheduler
    import iq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           disp_valid,
    output logic           disp_ready,
    input  iq_reg_t        disp_src1,
    input  iq_reg_t        disp_src2,
    input  iq_reg_t        disp_dest,
    input  logic           disp_src1_v,
    input  logic           disp_src2_v,
    input  logic           disp_dest_v,
    output iq_idx_t        alloc_idx,
    input  logic           wb_valid,
    input  iq_reg_t        wb_reg,
    input  logic           issue_stall,
    output logic           issue_valid,
    output iq_idx_t        issue_idx,
    output logic [IDX_W:0] count,
    output logic           full,
    output logic           empty
);
    logic [DEPTH-1:0]    valid_q, valid_d, pend1_q, pend1_d, pend2_q, pend2_d, ready, grant_oh;
    iq_reg_t             src1_q [DEPTH];
    iq_reg_t             src1_d [DEPTH];
    iq_reg_t             src2_q [DEPTH];
    iq_reg_t             src2_d [DEPTH];
    logic [NUM_REGS-1:0] sb_q, sb_d, sb_live;
    logic                issue_valid_q, issue_valid_d, accept, do_issue, grant_v;
    iq_idx_t             issue_idx_q, issue_idx_d, grant_idx;
    logic [IDX_W:0]      count_q, count_d;

    // scoreboard as seen by dispatch: a same-cycle writeback already counts as done
    assign sb_live     = sb_q & ~(NUM_REGS'(wb_valid) << wb_reg);
    assign full        = count_q == (IDX_W+1)'(DEPTH);
    assign empty       = count_q == '0;
    assign count       = count_q;
    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign disp_ready  = !full && !(disp_dest_v && disp_dest != '0 && sb_live[disp_dest]);
    assign accept      = disp_valid && disp_ready;
    assign ready       = valid_q & ~pend1_q & ~pend2_q;
    assign do_issue    = !issue_stall && grant_v;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) if (!valid_q[i]) alloc_idx = iq_idx_t'(i);
    end

    iq_age_select u_sel (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alloc     (accept && !flush),
        .alloc_idx (alloc_idx),
        .valid     (valid_q),
        .ready     (ready),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .grant_v   (grant_v)
    );

    always_comb begin
        valid_d = valid_q & ~(do_issue ? grant_oh : '0);
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        sb_d    = sb_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && src1_q[i] == wb_reg) pend1_d[i] = 1'b0;
            if (wb_valid && src2_q[i] == wb_reg) pend2_d[i] = 1'b0;
        end
        if (wb_valid) sb_d[wb_reg] = 1'b0;
        if (accept) begin
            valid_d[alloc_idx] = 1'b1;
            src1_d[alloc_idx]  = disp_src1;
            src2_d[alloc_idx]  = disp_src2;
            pend1_d[alloc_idx] = disp_src1_v && sb_live[disp_src1];
            pend2_d[alloc_idx] = disp_src2_v && sb_live[disp_src2];
            if (disp_dest_v) sb_d[disp_dest] = 1'b1;
        end
        sb_d[0]       = 1'b0;
        count_d       = count_q + (IDX_W+1)'(accept) - (IDX_W+1)'(do_issue);
        issue_valid_d = do_issue;
        issue_idx_d   = do_issue ? grant_idx : issue_idx_q;
        if (flush) begin
            valid_d       = '0;
            pend1_d       = '0;
            pend2_d       = '0;
            sb_d          = '0;
            count_d       = '0;
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q       <= '0;
            pend1_q       <= '0;
            pend2_q       <= '0;
            src1_q        <= '{default: '0};
            src2_q        <= '{default: '0};
            sb_q          <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
        end else begin
            valid_q       <= valid_d;
            pend1_q       <= pend1_d;
            pend2_q       <= pend2_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            sb_q          <= sb_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
        end
    end
endmodule

// File: tb/tb_iq_scheduler.sv
// tb_iq_scheduler: directed checks of dispatch, wakeup, select, WAW, stall, flush and reset.
module tb_iq_scheduler;
    import iq_pkg::*;
    logic           clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic           disp_valid = 1'b0, disp_ready;
    iq_reg_t        disp_src1 = '0, disp_src2 = '0, disp_dest = '0;
    logic           disp_src1_v = 1'b0, disp_src2_v = 1'b0, disp_dest_v = 1'b0;
    iq_idx_t        alloc_idx, issue_idx;
    logic           wb_valid = 1'b0, issue_stall = 1'b0, issue_valid, full, empty;
    iq_reg_t        wb_reg = '0;
    logic [IDX_W:0] count;
    int checks = 0, errors = 0;

    iq_scheduler dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_dest(disp_dest),
        .disp_src1_v(disp_src1_v), .disp_src2_v(disp_src2_v), .disp_dest_v(disp_dest_v),
        .alloc_idx(alloc_idx), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .issue_stall(issue_stall), .issue_valid(issue_valid), .issue_idx(issue_idx),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic v, input logic s1v, input int s1, input logic s2v,
                        input int s2, input logic dv, input int d);
        disp_valid  = v;
        disp_src1_v = s1v;
        disp_src1   = iq_reg_t'(s1);
        disp_src2_v = s2v;
        disp_src2   = iq_reg_t'(s2);
        disp_dest_v = dv;
        disp_dest   = iq_reg_t'(d);
        #1;
    endtask

    task automatic wb(input logic v, input int r);
        wb_valid = v;
        wb_reg   = iq_reg_t'(r);
        #1;
    endtask

    initial begin
        #12 rst = 1'b1;
        tick();
        // independent instruction: dispatch at N, issue after N+1
        disp(1, 1, 1, 1, 2, 1, 3);
        chk("ind_ready", disp_ready, 1);
        chk("ind_alloc", alloc_idx, 0);
        tick();
        disp(0, 0, 0, 0, 0, 0, 0);
        chk("ind_cnt1", count, 1);
        chk("ind_noiss", issue_valid, 0);
        tick();
        chk("ind_iss", issue_valid, 1);
        chk("ind_idx", issue_idx, 0);
        chk("ind_cnt0", count, 0);
        wb(1, 3);
        tick();
        wb(0, 0);
        // RAW: B waits on r5 until writeback
        disp(1, 0, 0, 0, 0, 1, 5);
        tick();
        disp(1, 1, 5, 0, 0, 1, 6);
        chk("raw_alloc", alloc_idx, 1);
        tick();
        disp(0, 0, 0, 0, 0, 0, 0);
        chk("raw_a_iss", issue_valid, 1);
        chk("raw_a_idx", issue_idx, 0);
        tick();
        chk("raw_b_wait", issue_valid, 0);
        chk("raw_b_cnt", count, 1);
        tick();
        wb(1, 5);
        tick();
        wb(0, 0);
        chk("raw_wake_edge", issue_valid, 0);
        tick();
        chk("raw_b_iss", issue_valid, 1);
        chk("raw_b_idx", issue_idx, 1);
        chk("raw_cnt0", count, 0);
        wb(1, 6);
        tick();
        wb(0, 0);
        // RAW with writeback in the same cycle as B's dispatch
        disp(1, 0, 0, 0, 0, 1, 5);
        tick();
        disp(1, 1, 5, 0, 0, 0, 0);
        wb(1, 5);
        tick();
        disp(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        chk("byp_a_idx", issue_idx, 0);
        tick();
        chk("byp_b_iss", issue_valid, 1);
        chk("byp_b_idx", issue_idx, 1);
        chk("byp_cnt0", count, 0);
        // fill all slots, all waiting on r7
        disp(1, 0, 0, 0, 0, 1, 7);
        tick();
        disp(0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            disp(1, 1, 7, 0, 0, 1, 8 + k);
            chk($sformatf("fill_alloc%0d", k), alloc_idx, k);
            tick();
        end
        disp(1, 0, 0, 0, 0, 0, 0);
        chk("full", full, 1);
        chk("full_cnt", count, DEPTH);
        chk("full_ready", disp_ready, 0);
        chk("full_noiss", issue_valid, 0);
        disp(0, 0, 0, 0, 0, 0, 0);
        wb(1, 7);
        tick();
        wb(0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            chk($sformatf("drain_v%0d", k), issue_valid, 1);
            chk($sformatf("drain_idx%0d", k), issue_idx, k);
        end
        tick();
        chk("drain_done", issue_valid, 0);
        chk("drain_empty", empty, 1);
        // WAW on r9 (still pending from the fill)
        disp(1, 0, 0, 0, 0, 1, 9);
        chk("waw_stall", disp_ready, 0);
        wb(1, 9);
        chk("waw_bypass", disp_ready, 1);
        tick();
        wb(0, 0);
        disp(1, 0, 0, 0, 0, 1, 9);
        chk("waw_cnt", count, 1);
        chk("waw_sb_kept", disp_ready, 0);
        disp(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("waw_iss", issue_valid, 1);
        // issue stall holds everything
        issue_stall = 1'b1;
        disp(1, 0, 0, 0, 0, 0, 0);
        tick();
        disp(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall_noiss%0d", k), issue_valid, 0);
            chk($sformatf("stall_cnt%0d", k), count, 1);
        end
        issue_stall = 1'b0;
        tick();
        chk("stall_rel_iss", issue_valid, 1);
        chk("stall_rel_cnt", count, 0);
        // flush with dispatch and writeback in the same cycle
        disp(1, 1, 10, 0, 0, 0, 0);
        tick();
        chk("fl_pre_cnt", count, 1);
        flush = 1'b1;
        disp(1, 0, 0, 0, 0, 1, 20);
        wb(1, 11);
        tick();
        flush = 1'b0;
        wb(0, 0);
        disp(1, 0, 0, 0, 0, 1, 12);
        chk("fl_cnt", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_noiss", issue_valid, 0);
        chk("fl_sb12", disp_ready, 1);
        disp(1, 0, 0, 0, 0, 1, 20);
        chk("fl_sb20", disp_ready, 1);
        // asynchronous reset in the middle of traffic
        disp(1, 0, 0, 0, 0, 1, 3);
        tick();
        disp(1, 0, 0, 0, 0, 1, 4);
        tick();
        chk("pre_rst_iss", issue_valid, 1);
        #2 rst = 1'b0;
        disp(1, 0, 0, 0, 0, 1, 3);
        chk("rst_cnt", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_iss", issue_valid, 0);
        chk("rst_ready", disp_ready, 1);
        chk("rst_alloc", alloc_idx, 0);
        disp(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
